cpu_jtag_ocimem_ctrl: RTL and testbench
=======================================

# cpu_jtag_ocimem_ctrl

On-chip debug memory controller for the Nios II JTAG debug path. It sits directly downstream of the debug module's system-clock stage and consumes the `jdo` word plus the OCI-memory action strobes. It executes address-load, read and write commands against a private debug RAM with auto-incrementing address. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug module's TCK stage for shift-out.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; RAM depth is 2^ADDR_W 32-bit words.

Ports:
- `clk`  in  1: system clock. One clock only; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high reset.
- `jdo`  in  38: JTAG data word, already in the `clk` domain.
- `take_action_ocimem_a`  in  1: one-cycle strobe, address/command load.
- `take_no_action_ocimem_a`  in  1: one-cycle strobe, read at the current address.
- `take_action_ocimem_b`  in  1: one-cycle strobe, write at the current address.
- `MonDReg`  out  32: last read data.
- `MonAReg`  out  ADDR_W: current word address.
- `monitor_ready`  out  1: `MonDReg` holds the result of the most recent read.
- `monitor_error`  out  1: sticky protocol/wrap error.

## Operation
- FSM states:
  - IDLE: accepts strobes.
  - RD: one cycle; RAM output is valid.
- RAM: 2^ADDR_W x 32, single port, synchronous read with 1-cycle latency, write-first not required. Contents are not cleared by reset.
- Strobe priority when several are asserted in the same cycle: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes in that cycle are dropped silently.
- Address load (`take_action_ocimem_a`, IDLE):
  - `MonAReg <= jdo[17+ADDR_W-1:17]`.
  - `monitor_error` and `monitor_ready` clear to 0.
  - If `jdo[34]`=1, a read of the newly loaded address starts at the same edge; the RAM is addressed from jdo directly.
- Write (`take_action_ocimem_b`, IDLE):
  - `ram[MonAReg] <= jdo[34:3]`.
  - `MonAReg` increments.
  - `monitor_ready` clears.
- Read (`take_no_action_ocimem_a`, or address load with `jdo[34]`=1):
  - RAM is addressed with the target address.
  - `MonAReg` increments, except that after an address load it becomes loaded+1.
  - `monitor_ready` clears and the FSM goes to RD.
  - In RD: `MonDReg <= ram_q`, `monitor_ready <= 1`, FSM returns to IDLE.
- Auto-increment is modulo 2^ADDR_W. An increment from 2^ADDR_W-1 to 0 sets `monitor_error`.
- Any strobe arriving while in RD is ignored (no RAM or address change) and sets `monitor_error`.
- `monitor_error` is cleared only by reset or by an address load.

## Timing
- Reset values:
  - `MonDReg`=0
  - `MonAReg`=0
  - `monitor_ready`=0
  - `monitor_error`=0
  - FSM=IDLE
- Reset asserted while in RD: the pending read is abandoned and `MonDReg` stays 0.
- Strobe sampled at edge E:
  - Address and write take effect at E.
  - Read data appears in `MonDReg`, with `monitor_ready`=1, at edge E+1.
- Throughput: a write is accepted every cycle. A read is accepted every 2 cycles; back-to-back read strobes on consecutive cycles flag an error on the second.
- `monitor_ready` stays high until the next accepted command. `MonDReg` holds its value until the next read completes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0. Write jdo[34:3]=0xDEADBEEF at addr 0 -> `MonAReg`=1 at the strobe edge. Load addr 0 with `jdo[34]`=1 -> one cycle later `MonDReg`=0xDEADBEEF, `monitor_ready`=1, `MonAReg`=1.
- Load addr 0x10, write 0x11111111, 0x22222222, 0x33333333 on consecutive cycles -> `MonAReg`=0x13. Reload 0x10 and do three reads with a gap of 1 cycle -> `MonDReg` sequence 0x11111111/0x22222222/0x33333333, `monitor_error`=0.
- Load addr 0xFF (ADDR_W=8) and write -> `MonAReg`=0x00, `monitor_error`=1. Then a further write succeeds with the error still 1. Address load -> `monitor_error`=0.
- Read strobe followed by a write strobe on the next cycle -> the write is ignored (RAM location unchanged on readback), `monitor_error`=1, `MonAReg` incremented once only.
- Assert `take_action_ocimem_a` and `take_action_ocimem_b` in the same cycle -> only the address load occurs (`MonAReg`=jdo field, RAM unchanged).
- Issue a read, assert `reset` on the next cycle -> `MonDReg`=0, `monitor_ready`=0, FSM in IDLE. RAM data written before reset still reads back correctly afterwards.

Source files
------------

// File: rtl/cpu_jtag_ocimem_ctrl_if.sv
// Command/response bundle between the JTAG debug module clk stage and the
// OCI debug-memory controller.
interface cpu_jtag_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready;
  logic              monitor_error;

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  MonDReg, MonAReg, monitor_ready, monitor_error
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output MonDReg, MonAReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/cpu_jtag_ocimem_ctrl.sv
// OCI debug memory controller: address-load / read / write commands against a
// private single-port debug RAM with auto-incrementing word address.
module cpu_jtag_ocimem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  cpu_jtag_ocimem_ctrl_if.slave   bus
);

  typedef enum logic {S_IDLE, S_RD} state_t;

  state_t            state;
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;
  logic [31:0]       mon_d;
  logic [ADDR_W-1:0] mon_a;
  logic              mon_ready;
  logic              mon_error;

  logic              st_a, st_b, st_n;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              idle_ok;
  logic              wr_en;
  logic              rd_en;
  logic              unused_jdo;

  assign st_a      = bus.take_action_ocimem_a;
  assign st_b      = bus.take_action_ocimem_b;
  assign st_n      = bus.take_no_action_ocimem_a;
  assign load_addr = bus.jdo[17 +: ADDR_W];
  assign unused_jdo = ^{bus.jdo[37:35], bus.jdo[2:0]};

  // Priority a > b > n; a load with jdo[34] set reads straight from the jdo address.
  always_comb begin
    idle_ok = (state == S_IDLE) && !reset;
    wr_en   = idle_ok && !st_a && st_b;
    rd_en   = idle_ok && (st_a ? bus.jdo[34] : (!st_b && st_n));
    rd_addr = st_a ? load_addr : mon_a;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[mon_a] <= bus.jdo[34:3];
    if (rd_en) ram_q <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mon_d     <= '0;
      mon_a     <= '0;
      mon_ready <= 1'b0;
      mon_error <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (st_a) begin
            mon_ready <= 1'b0;
            if (bus.jdo[34]) begin
              // Wrap on the post-load increment still counts as an error.
              mon_a     <= load_addr + 1'b1;
              mon_error <= &load_addr;
              state     <= S_RD;
            end else begin
              mon_a     <= load_addr;
              mon_error <= 1'b0;
            end
          end else if (st_b || st_n) begin
            mon_a     <= mon_a + 1'b1;
            mon_ready <= 1'b0;
            if (&mon_a) mon_error <= 1'b1;
            if (!st_b) state <= S_RD;
          end
        end
        S_RD: begin
          mon_d     <= ram_q;
          mon_ready <= 1'b1;
          if (st_a || st_b || st_n) mon_error <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.MonDReg       = mon_d;
  assign bus.MonAReg       = mon_a;
  assign bus.monitor_ready = mon_ready;
  assign bus.monitor_error = mon_error;

endmodule

// File: tb/tb_cpu_jtag_ocimem_ctrl.sv
// Self-checking bench for cpu_jtag_ocimem_ctrl: transaction-level model plus
// directed literal checks and randomized command traffic.
module tb_cpu_jtag_ocimem_ctrl;
  localparam int unsigned ADDR_W = 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_jtag_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_jtag_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: memory array, current address, last result, pending read.
  logic [31:0] mem [DEPTH];
  int          m_addr = 0;
  logic [31:0] m_data = '0;
  bit          m_ready = 1'b0;
  bit          m_err = 1'b0;
  bit          m_busy = 1'b0;
  logic [31:0] m_pend = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bump();
    if (m_addr == DEPTH - 1) m_err = 1'b1;
    m_addr = (m_addr + 1) % DEPTH;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_addr = 0; m_data = '0; m_ready = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_data  = m_pend;
      m_ready = 1'b1;
      m_busy  = 1'b0;
      if (bus.take_action_ocimem_a || bus.take_action_ocimem_b || bus.take_no_action_ocimem_a)
        m_err = 1'b1;
    end else if (bus.take_action_ocimem_a) begin
      m_addr  = int'(bus.jdo[17 +: ADDR_W]);
      m_err   = 1'b0;
      m_ready = 1'b0;
      if (bus.jdo[34]) begin
        m_pend = mem[m_addr];
        bump();
        m_busy = 1'b1;
      end
    end else if (bus.take_action_ocimem_b) begin
      mem[m_addr] = bus.jdo[34:3];
      bump();
      m_ready = 1'b0;
    end else if (bus.take_no_action_ocimem_a) begin
      m_pend = mem[m_addr];
      bump();
      m_ready = 1'b0;
      m_busy  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_MonDReg", bus.MonDReg, m_data);
      chk("cmp_MonAReg", 32'(bus.MonAReg), 32'(m_addr));
      chk("cmp_ready", 32'(bus.monitor_ready), 32'(m_ready));
      chk("cmp_error", 32'(bus.monitor_error), 32'(m_err));
    end
  end

  function automatic logic [37:0] jload(input int addr, input bit rd);
    logic [37:0] j;
    j = '0;
    j[17 +: ADDR_W] = ADDR_W'(addr);
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jwr(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  task automatic drive(input bit a, input bit b, input bit n, input logic [37:0] j, input bit r = 1'b0);
    rst = r;
    bus.take_action_ocimem_a    = a;
    bus.take_action_ocimem_b    = b;
    bus.take_no_action_ocimem_a = n;
    bus.jdo = j;
    @(negedge clk);
    rst = 1'b0;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.jdo = '0;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, '0, 1'b1);
    chk_en = 1'b1;

    // Fill RAM so every later read has a known value.
    drive(1, 0, 0, jload(0, 0));
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, jwr($urandom()));

    drive(0, 0, 0, '0, 1'b1);
    idle(5);
    chk("rst_MonDReg", bus.MonDReg, 32'h0);
    chk("rst_MonAReg", 32'(bus.MonAReg), 32'h0);
    chk("rst_ready", 32'(bus.monitor_ready), 32'h0);
    chk("rst_error", 32'(bus.monitor_error), 32'h0);

    drive(0, 1, 0, jwr(32'hDEADBEEF));
    chk("wr0_MonAReg", 32'(bus.MonAReg), 32'h1);
    drive(1, 0, 0, jload(0, 1));
    chk("ldrd_MonAReg", 32'(bus.MonAReg), 32'h1);
    idle(1);
    chk("ldrd_MonDReg", bus.MonDReg, 32'hDEADBEEF);
    chk("ldrd_ready", 32'(bus.monitor_ready), 32'h1);

    drive(1, 0, 0, jload(16, 0));
    drive(0, 1, 0, jwr(32'h11111111));
    drive(0, 1, 0, jwr(32'h22222222));
    drive(0, 1, 0, jwr(32'h33333333));
    chk("burst_MonAReg", 32'(bus.MonAReg), 32'h13);
    drive(1, 0, 0, jload(16, 0));
    drive(0, 0, 1, '0); idle(1);
    chk("rd1", bus.MonDReg, 32'h11111111);
    drive(0, 0, 1, '0); idle(1);
    chk("rd2", bus.MonDReg, 32'h22222222);
    drive(0, 0, 1, '0); idle(1);
    chk("rd3", bus.MonDReg, 32'h33333333);
    chk("rd_error", 32'(bus.monitor_error), 32'h0);

    drive(1, 0, 0, jload(255, 0));
    drive(0, 1, 0, jwr(32'hCAFEF00D));
    chk("wrap_MonAReg", 32'(bus.MonAReg), 32'h0);
    chk("wrap_error", 32'(bus.monitor_error), 32'h1);
    drive(0, 1, 0, jwr(32'h0BADF00D));
    chk("postwrap_MonAReg", 32'(bus.MonAReg), 32'h1);
    chk("postwrap_error", 32'(bus.monitor_error), 32'h1);
    drive(1, 0, 0, jload(32, 0));
    chk("ld_clr_error", 32'(bus.monitor_error), 32'h0);

    drive(1, 0, 0, jload(48, 0));
    drive(0, 1, 0, jwr(32'hAAAA0000));
    drive(0, 1, 0, jwr(32'hBBBB1111));
    drive(1, 0, 0, jload(48, 0));
    drive(0, 0, 1, '0);
    drive(0, 1, 0, jwr(32'h55555555));
    chk("rdwr_error", 32'(bus.monitor_error), 32'h1);
    chk("rdwr_MonAReg", 32'(bus.MonAReg), 32'h31);
    drive(1, 0, 0, jload(49, 1)); idle(1);
    chk("rdwr_ram", bus.MonDReg, 32'hBBBB1111);

    drive(1, 0, 0, jload(82, 0));
    drive(0, 1, 0, jwr(32'hEEEE2222));
    drive(1, 0, 0, jload(82, 0));
    drive(1, 1, 0, jload(64, 0));
    chk("ab_MonAReg", 32'(bus.MonAReg), 32'h40);
    drive(1, 0, 0, jload(82, 1)); idle(1);
    chk("ab_ram", bus.MonDReg, 32'hEEEE2222);

    drive(1, 0, 0, jload(16, 0));
    drive(0, 0, 1, '0);
    drive(0, 0, 0, '0, 1'b1);
    chk("rstrd_MonDReg", bus.MonDReg, 32'h0);
    chk("rstrd_ready", 32'(bus.monitor_ready), 32'h0);
    drive(1, 0, 0, jload(16, 1)); idle(1);
    chk("rstrd_ram", bus.MonDReg, 32'h11111111);
    chk("rstrd_ready1", 32'(bus.monitor_ready), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      logic [37:0] j;
      j = 38'({$urandom(), $urandom()});
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 35, j, $urandom_range(0, 299) == 0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
